keypad_scanner: RTL

//  Drives the 4x4 matrix keypad columns and reads its rows. Produces the raw key code and
//  key_pressed pair consumed by the debouncer (its sig_in / key_pressed inputs).

---
 rtl/keypad_scanner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad. One column is driven low at a time;
// the rows (pulled up) are synchronised and sampled at the end of each column
// dwell. The first key found is locked in and reported until it is released.
// A release must stay stable for a full window before it is accepted, so
// contact bounce on release does not drop key_pressed.
//
// Parameters
//   SCAN_DIV     clk cycles per column dwell and per release-confirm window (>= 4)
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-low reset
//   rows         in   4  keypad rows, active-low, asynchronous to clk
//   cols         out  4  column drive, active-low, exactly one bit low
//   key_code     out  4  hex code of the held / last key
//   key_pressed  out  1  high while a key is held (incl. release-confirm window)
//   dbg_state    out  2  current FSM state (0 SCAN, 1 HOLD, 2 RELEASE)
//
// Handshake: none. key_code is valid whenever key_pressed is high and keeps
// its last value afterwards; it only changes on the cycle key_pressed rises.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV = 4800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_pressed,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    cols_q, cols_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_pressed_q, key_pressed_d;
    logic [3:0]    rows_meta_q;
    logic [3:0]    srows_q;

    logic          cnt_last;
    logic          any_low;
    logic [1:0]    low_row;
    logic          key_up;

    // Key legend indexed by [row][col].
    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign cnt_last = (cnt_q == CNT_LAST);
    assign any_low  = (srows_q != 4'hF);
    // Only the locked row is watched; other rows are ignored while a key is held.
    assign key_up   = srows_q[row_q];

    // Lowest-index low row wins when several rows are low in the driven column.
    always_comb begin
        low_row = 2'd3;
        if (!srows_q[2]) low_row = 2'd2;
        if (!srows_q[1]) low_row = 2'd1;
        if (!srows_q[0]) low_row = 2'd0;
    end

    // State and datapath registers, plus the two-flop row synchroniser.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_SCAN;
            cnt_q         <= '0;
            col_q         <= 2'd0;
            cols_q        <= 4'b1110;
            row_q         <= 2'd0;
            key_code_q    <= 4'h0;
            key_pressed_q <= 1'b0;
            rows_meta_q   <= 4'hF;
            srows_q       <= 4'hF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            cols_q        <= cols_d;
            row_q         <= row_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
            rows_meta_q   <= rows;
            srows_q       <= rows_meta_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: begin
                if (cnt_last && any_low) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (key_up) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!key_up)       state_d = ST_HOLD;
                else if (cnt_last) state_d = ST_SCAN;
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        cnt_d         = cnt_q;
        col_d         = col_q;
        cols_d        = cols_q;
        row_d         = row_q;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        case (state_q)
            ST_SCAN: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (any_low) begin
                        // Column stays frozen on the key that was found.
                        row_d         = low_row;
                        key_code_d    = map_key(low_row, col_q);
                        key_pressed_d = 1'b1;
                    end else begin
                        col_d  = col_q + 2'd1;
                        cols_d = {cols_q[2:0], cols_q[3]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                cnt_d = '0;
            end
            ST_RELEASE: begin
                if (!key_up) begin
                    cnt_d = '0;
                end else if (cnt_last) begin
                    // Release confirmed: resume scanning at the next column.
                    cnt_d         = '0;
                    key_pressed_d = 1'b0;
                    col_d         = col_q + 2'd1;
                    cols_d        = {cols_q[2:0], cols_q[3]};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign cols        = cols_q;
    assign key_code    = key_code_q;
    assign key_pressed = key_pressed_q;
    assign dbg_state   = state_q;

endmodule
